// File: rtl/dsp_adder_arbiter_pkg.sv
// Shared definitions for the DSP adder arbiter: FSM state encodings and id sizing.
// Optional subtract support is enabled by defining DSP_ADDER_ARB_SUB_EN.
package dsp_adder_arbiter_pkg;

  localparam int NREQ_MAX = 8;
  localparam int ID_W     = $clog2(NREQ_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dsp_adder_arbiter_adder_dsp.sv
// 32-bit adder mapped onto a DSP slice; is_sub selects A + ~B + 1.
module adder_dsp (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_sub,
  output logic [31:0] sum
);

  // Carry-out is deliberately dropped: results wrap modulo 2^32.
  assign sum = a + (b ^ {32{is_sub}}) + {31'd0, is_sub};

endmodule

// File: rtl/dsp_adder_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index strictly after rr_ptr, cyclic.
// Kept standalone so other arbiters can reuse it.
module rr_picker
  import dsp_adder_arbiter_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [ID_W-1:0] grant_idx,
  output logic            grant_any
);

  // NOTE: combinational logic uses blocking (=) assignments and gives every
  // output a default first, so no latch is inferred on paths that skip a write.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + off) % NREQ]) begin
        grant_any                                  = 1'b1;
        grant_oh[(int'(rr_ptr) + off) % NREQ]      = 1'b1;
        grant_idx                                  = ID_W'((int'(rr_ptr) + off) % NREQ);
      end
    end
  end

endmodule

// File: rtl/dsp_adder_arbiter.sv
// Shares one adder_dsp among NREQ requesters with round-robin grants and valid/ready handshakes.
// Define DSP_ADDER_ARB_SUB_EN to honour req_sub; otherwise every op is A+B.
module dsp_adder_arbiter
  import dsp_adder_arbiter_pkg::*;
#(
  parameter int NREQ  = 3,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_sub,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data
);

  state_t            r_state, w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [WIDTH-1:0]  w_a_sel, w_b_sel;
  logic [WIDTH-1:0]  w_sum;
  logic              w_is_sub;
  logic [NREQ-1:0]   w_grant_oh;
  logic [ID_W-1:0]   w_grant_idx;
  logic              w_grant_any;
  logic [NREQ-1:0]   w_id_oh;
  logic              w_accept;
  logic              w_grant_en;
  logic              w_hs;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (r_rr_ptr),
    .grant_oh  (w_grant_oh),
    .grant_idx (w_grant_idx),
    .grant_any (w_grant_any)
  );

  always_comb begin
    w_id_oh = '0;
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_id_oh[i] = (r_id == ID_W'(i));
      if (w_grant_oh[i]) begin
        w_a_sel = req_a[i*WIDTH +: WIDTH];
        w_b_sel = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Only the owner of the pending response can retire it.
  assign w_accept = (r_state == ST_DONE) && |(w_id_oh & resp_ready);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_en = 1'b1;
        if (w_grant_any) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: w_state_nxt = ST_DONE;
      ST_DONE: begin
        if (w_accept) begin
          w_grant_en  = 1'b1;
          w_state_nxt = w_grant_any ? ST_EXEC : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_hs       = w_grant_en & w_grant_any;
  assign req_ready  = w_grant_en ? w_grant_oh : '0;
  assign resp_valid = (r_state == ST_DONE) ? w_id_oh : '0;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_rr_ptr  <= ID_W'(NREQ - 1);
      r_id      <= '0;
      resp_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_rr_ptr <= w_grant_idx;
        r_id     <= w_grant_idx;
      end
      if (r_state == ST_EXEC) resp_data <= w_sum;
    end
  end

  // NOTE: operand registers carry no reset; they are only read in EXEC,
  // which is reachable solely through a handshake that loads them.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_a <= w_a_sel;
      r_b <= w_b_sel;
    end
  end

`ifdef DSP_ADDER_ARB_SUB_EN
  logic r_sub;
  logic w_sub_sel;

  assign w_sub_sel = |(w_grant_oh & req_sub);

  always_ff @(posedge clk) begin
    if (w_hs) r_sub <= w_sub_sel;
  end

  assign w_is_sub = r_sub;
`else
  logic w_unused_sub;
  assign w_unused_sub = ^req_sub;
  assign w_is_sub     = 1'b0;
`endif

  adder_dsp u_adder (
    .a      (r_a),
    .b      (r_b),
    .is_sub (w_is_sub),
    .sum    (w_sum)
  );

endmodule

// File: tb/tb_dsp_adder_arbiter.sv
// Directed bench for dsp_adder_arbiter (NREQ=3, WIDTH=32); honours DSP_ADDER_ARB_SUB_EN.
module tb_dsp_adder_arbiter;

  localparam int NREQ  = 3;
  localparam int WIDTH = 32;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready;
  logic [WIDTH-1:0]      resp_data;

  int n_checks = 0;
  int n_fail   = 0;

  dsp_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sub    (req_sub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Leaves the bench at a falling edge with reset released and inputs idle.
  task automatic do_reset();
    reset      = 1'b1;
    req_valid  = '0;
    req_sub    = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (req_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 000", req_ready);
    end
    n_checks++;
    if (resp_valid !== 3'b000) begin
      n_fail++; $display("FAIL reset_resp_valid: got %b want 000", resp_valid);
    end
    n_checks++;
    if (resp_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_ops(0, 32'd5, 32'd7);
    req_valid = 3'b001;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL single_grant: got %b want 001", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    set_ops(0, 32'hDEAD_BEEF, 32'h1234_5678);
    #1;
    n_checks++;
    if (resp_valid !== 3'b000 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL single_exec_quiet: resp_valid %b req_ready %b want 000/000", resp_valid, req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b001) begin
      n_fail++; $display("FAIL single_resp_valid: got %b want 001", resp_valid);
    end
    n_checks++;
    if (resp_data !== 32'd12) begin
      n_fail++; $display("FAIL single_resp_data: got %0d want 12", resp_data);
    end
    resp_ready = 3'b001;
    @(negedge clk);
    resp_ready = 3'b000;
    #1;
    n_checks++;
    if (resp_valid !== 3'b000) begin
      n_fail++; $display("FAIL single_after_accept: got %b want 000", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int seq [5];
    logic [31:0] sums [3];
    logic [2:0] exp_rdy, exp_rv;
    seq  = '{0, 1, 2, 0, 1};
    sums = '{32'd107, 32'd208, 32'd309};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(100 * (i + 1)), 32'(i + 7));
    req_valid  = 3'b111;
    resp_ready = 3'b111;
    for (int k = 0; k <= 8; k++) begin
      #1;
      exp_rdy = (k % 2 == 0) ? 3'(1 << seq[k/2]) : 3'b000;
      exp_rv  = (k >= 2 && k % 2 == 0) ? 3'(1 << seq[k/2 - 1]) : 3'b000;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL rr_req_ready[c%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
      n_checks++;
      if (resp_valid !== exp_rv) begin
        n_fail++; $display("FAIL rr_resp_valid[c%0d]: got %b want %b", k, resp_valid, exp_rv);
      end
      if (k >= 2 && k % 2 == 0) begin
        n_checks++;
        if (resp_data !== sums[seq[k/2 - 1]]) begin
          n_fail++; $display("FAIL rr_resp_data[c%0d]: got %0d want %0d", k, resp_data, sums[seq[k/2 - 1]]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    set_ops(0, 32'hFFFF_FFFF, 32'd1);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = 3'b000;
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b001 || resp_data !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_result: resp_valid %b data %h want 001/00000000", resp_valid, resp_data);
    end
    resp_ready = 3'b001;
    @(negedge clk);
    resp_ready = 3'b000;
    #1;
    n_checks++;
    if (resp_valid !== 3'b000 || req_ready !== 3'b000) begin
      n_fail++; $display("FAIL wrap_side_effect: resp_valid %b req_ready %b want 000/000", resp_valid, req_ready);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_ops(0, 32'd40, 32'd2);
    set_ops(1, 32'd1000, 32'd24);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = 3'b010;
    @(negedge clk);
    // Non-owner ready must be ignored while req 0's response is pending.
    resp_ready = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (resp_valid !== 3'b001 || resp_data !== 32'd42) begin
        n_fail++; $display("FAIL hold_resp[%0d]: resp_valid %b data %0d want 001/42", k, resp_valid, resp_data);
      end
      n_checks++;
      if (req_ready !== 3'b000) begin
        n_fail++; $display("FAIL hold_req_ready[%0d]: got %b want 000", k, req_ready);
      end
      @(negedge clk);
    end
    resp_ready = 3'b011;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      n_fail++; $display("FAIL accept_cycle_grant: got %b want 010", req_ready);
    end
    @(negedge clk);
    req_valid  = 3'b000;
    resp_ready = 3'b000;
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b010 || resp_data !== 32'd1024) begin
      n_fail++; $display("FAIL backpressure_next: resp_valid %b data %0d want 010/1024", resp_valid, resp_data);
    end
  endtask

  task automatic test_sub();
    logic [31:0] exp;
`ifdef DSP_ADDER_ARB_SUB_EN
    exp = 32'hFFFF_FFFE;
`else
    exp = 32'd8;
`endif
    do_reset();
    set_ops(2, 32'd3, 32'd5);
    req_sub   = 3'b100;
    req_valid = 3'b100;
    #1;
    n_checks++;
    if (req_ready !== 3'b100) begin
      n_fail++; $display("FAIL sub_grant: got %b want 100", req_ready);
    end
    @(negedge clk);
    req_valid = 3'b000;
    req_sub   = 3'b000;
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b100 || resp_data !== exp) begin
      n_fail++; $display("FAIL sub_result: resp_valid %b data %h want 100/%h", resp_valid, resp_data, exp);
    end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'(i + 1), 32'(10 * (i + 1)));
    req_valid  = 3'b111;
    resp_ready = 3'b111;
    // Grants at c0 (req0), c2 (req1), c4 (req2); c5 is EXEC for req 2.
    repeat (5) @(negedge clk);
    reset      = 1'b1;
    req_valid  = 3'b000;
    resp_ready = 3'b000;
    @(negedge clk);
    #1;
    n_checks++;
    if (req_ready !== 3'b000 || resp_valid !== 3'b000 || resp_data !== 32'd0) begin
      n_fail++; $display("FAIL midreset_outputs: req_ready %b resp_valid %b data %h want 000/000/0", req_ready, resp_valid, resp_data);
    end
    reset     = 1'b0;
    req_valid = 3'b111;
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      n_fail++; $display("FAIL midreset_regrant: got %b want 001", req_ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b000) begin
      n_fail++; $display("FAIL midreset_no_stale_resp: got %b want 000", resp_valid);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (resp_valid !== 3'b001 || resp_data !== 32'd11) begin
      n_fail++; $display("FAIL midreset_first_resp: resp_valid %b data %0d want 001/11", resp_valid, resp_data);
    end
    req_valid = 3'b000;
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_sub    = '0;
    resp_ready = '0;
    req_a      = '0;
    req_b      = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_sub();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
